i2so_ctrl: RTL and testbench
============================

Name: i2so_ctrl

Overview:
- Sequencer for the I2S output path.
- Divides the master clock into the serial bit clock `sck` and produces the one-cycle `sck_transition` strobe that paces the serializer.
- Starts the path only once the output FIFO holds data. Stops it cleanly on a stereo-frame boundary when software deasserts enable.
- Keeps a frame counter for software.

Parameters:
- DIV_W, 8, width of the sck half-period divider value.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  input  1  master clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- rf_i2so_en  input  1  software enable for the output path.
- rf_sck_div  input  DIV_W  sck half-period in clk cycles; 0 is treated as 1.
- fifo_rts  input  1  output FIFO has data.
- i2so_ws  input  1  word select from the serializer; 0 = left, 1 = right.
- trig_frame_cnt  input  1  one-cycle pulse that clears ro_frame_cnt.
- sck  output  1  serial bit clock, registered.
- sck_transition  output  1  one-clk pulse in the cycle sck goes 0->1.
- ctrl_busy  output  1  high when state is not IDLE.
- ctrl_state  output  2  current state: IDLE=0, RUN=1, DRAIN=2.
- ro_frame_cnt  output  FCNT_W  completed frames, saturating.

Behaviour:
- Reset values: state=IDLE, sck=0, sck_transition=0, ctrl_busy=0, ctrl_state=0, ro_frame_cnt=0, divider count=0, ws_q=0, div_lat=1.
- Divider:
  - div_lat captures max(rf_sck_div,1) only while in IDLE; it is frozen in RUN and DRAIN.
  - In RUN and DRAIN, cnt counts 0..div_lat-1.
  - At cnt==div_lat-1: cnt<=0 and sck toggles.
  - sck_transition=1 in the same cycle the sck register becomes 1, so sck period = 2*div_lat clk cycles.
- Frame boundary:
  - ws_q registers i2so_ws every clk.
  - ws_fall = ws_q & ~i2so_ws.
- FSM:
  - IDLE: sck held 0, cnt held 0, no strobes. Go to RUN when rf_i2so_en & fifo_rts. The first sck rising edge, with its strobe, occurs div_lat cycles after entering RUN.
  - RUN: divider free-runs. Go to DRAIN when rf_i2so_en=0. FIFO empty does not stop RUN; the serializer underrun flag handles that case.
  - DRAIN: divider keeps running. On ws_fall go to IDLE. In the cycle of that transition: sck<=0, cnt<=0, no strobe.
  - DRAIN with rf_i2so_en reasserted: return to RUN with no gap in sck.
  - Enable high and low in the same cycle cannot occur (level signal). Enable toggled inside one divider period is still handled correctly, because transitions are evaluated every clk.
- Frame counter:
  - Increments on each ws_fall while in RUN or DRAIN.
  - Saturates at all-ones.
  - trig_frame_cnt clears it to 0; a clear wins over a simultaneous increment.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); sck drops to 0 with no pulse.
- ctrl_busy and ctrl_state are registered alongside the state register: no extra latency, no combinational paths from inputs.

Decomposition:
- Shared package i2so_pkg holds:
  - state encodings IDLE/RUN/DRAIN (2-bit);
  - default DIV_W and FCNT_W.
- One sub-module, i2so_sck_gen, holds the divider counter, the sck register and the sck_transition generation. Its ports are run, div_lat, sck, sck_transition, where run is high in RUN and DRAIN.
- The FSM, edge detector and frame counter stay in i2so_ctrl.

Test Plan:
- Reset, then rf_sck_div=4, en=1, fifo_rts=1 -> RUN next cycle; first sck_transition 4 clks later; sck period 8 clks; one strobe per period.
- rf_sck_div=0 -> behaves as 1: sck toggles every clk, strobe every 2 clks. Changing rf_sck_div to 9 while in RUN has no effect until after a return to IDLE.
- en=1 with fifo_rts=0 -> stays IDLE with sck=0; raise fifo_rts -> RUN next cycle.
- In RUN, drop en mid-frame -> DRAIN. sck continues until the next ws 1->0, then IDLE with sck=0. ro_frame_cnt has counted that final boundary.
- From DRAIN, reassert en before the ws fall -> back to RUN with no missing sck edge.
- Preload ro_frame_cnt to 0xFFFF via 65535 frames (or force) -> stays 0xFFFF. Pulse trig_frame_cnt coincident with ws_fall -> 0. Assert rst mid-RUN -> all outputs return to reset values at once.

Source files
------------

// File: rtl/i2so_pkg.sv
// ----------------------------------------------------------------------------
// i2so_pkg : shared state encoding and default widths for the I2S output path
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package i2so_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_DIV_W  = 8;
  localparam int DEF_FCNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/i2so_sck_gen.sv
// ----------------------------------------------------------------------------
// i2so_sck_gen : sck divider with one-clk strobe on each sck rising edge
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2so_sck_gen
  import i2so_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div_lat,
  output logic             sck,
  output logic             sck_transition
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             strb_q, strb_d;

  // div_lat is never 0, so the terminal count div_lat-1 is always reachable.
  always_comb begin
    cnt_d  = '0;
    sck_d  = 1'b0;
    strb_d = 1'b0;
    if (run) begin
      if (cnt_q == div_lat - DIV_W'(1)) begin
        cnt_d  = '0;
        sck_d  = ~sck_q;
        strb_d = ~sck_q;
      end else begin
        cnt_d  = cnt_q + DIV_W'(1);
        sck_d  = sck_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sck_q  <= 1'b0;
      strb_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      strb_q <= strb_d;
    end
  end

  assign sck            = sck_q;
  assign sck_transition = strb_q;

endmodule

`default_nettype wire

// File: rtl/i2so_ctrl.sv
// ----------------------------------------------------------------------------
// i2so_ctrl : I2S output sequencer - start/stop FSM, sck divider, frame counter
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2so_ctrl
  import i2so_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int FCNT_W = DEF_FCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_i2so_en,
  input  logic [DIV_W-1:0]  rf_sck_div,
  input  logic              fifo_rts,
  input  logic              i2so_ws,
  input  logic              trig_frame_cnt,
  output logic              sck,
  output logic              sck_transition,
  output logic              ctrl_busy,
  output logic [1:0]        ctrl_state,
  output logic [FCNT_W-1:0] ro_frame_cnt
);

  state_e             state_q, state_d;
  logic               ws_q;
  logic [DIV_W-1:0]   div_lat_q;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               ws_fall;
  logic               run;

  assign ws_fall = ws_q & ~i2so_ws;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rf_i2so_en && fifo_rts) state_d = ST_RUN;
      ST_RUN:   if (!rf_i2so_en)            state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (rf_i2so_en)   state_d = ST_RUN;
        else if (ws_fall) state_d = ST_IDLE;
      end
      default:            state_d = ST_IDLE;
    endcase
  end

  // Looking at state_d lets the DRAIN->IDLE edge park sck low in the same cycle.
  assign run = (state_q != ST_IDLE) && (state_d != ST_IDLE);

  always_comb begin
    fcnt_d = fcnt_q;
    if (trig_frame_cnt) begin
      fcnt_d = '0;
    end else if (ws_fall && (state_q != ST_IDLE) && (fcnt_q != '1)) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ws_q      <= 1'b0;
      div_lat_q <= DIV_W'(1);
      fcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      ws_q    <= i2so_ws;
      fcnt_q  <= fcnt_d;
      if (state_q == ST_IDLE) begin
        div_lat_q <= (rf_sck_div == '0) ? DIV_W'(1) : rf_sck_div;
      end
    end
  end

  i2so_sck_gen #(
    .DIV_W (DIV_W)
  ) u_sck_gen (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .div_lat        (div_lat_q),
    .sck            (sck),
    .sck_transition (sck_transition)
  );

  assign ctrl_state   = state_q;
  assign ctrl_busy    = (state_q != ST_IDLE);
  assign ro_frame_cnt = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_i2so_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2so_ctrl : directed table-driven bench for i2so_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i2so_ctrl;

  logic        clk;
  logic        rst;
  logic        rf_i2so_en;
  logic [7:0]  rf_sck_div;
  logic        fifo_rts;
  logic        i2so_ws;
  logic        trig_frame_cnt;
  logic        sck;
  logic        sck_transition;
  logic        ctrl_busy;
  logic [1:0]  ctrl_state;
  logic [15:0] ro_frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        rts;
    logic [7:0]  div;
    logic        ws;
    logic        trig;
    logic [1:0]  st;
    logic        sck;
    logic        strb;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];

  i2so_ctrl #(
    .DIV_W  (8),
    .FCNT_W (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rf_i2so_en     (rf_i2so_en),
    .rf_sck_div     (rf_sck_div),
    .fifo_rts       (fifo_rts),
    .i2so_ws        (i2so_ws),
    .trig_frame_cnt (trig_frame_cnt),
    .sck            (sck),
    .sck_transition (sck_transition),
    .ctrl_busy      (ctrl_busy),
    .ctrl_state     (ctrl_state),
    .ro_frame_cnt   (ro_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic rts, input logic [7:0] div,
                              input logic ws, input logic trig, input logic [1:0] st,
                              input logic sck_e, input logic strb, input logic [15:0] fc);
    vec_t v;
    v.en = en; v.rts = rts; v.div = div; v.ws = ws; v.trig = trig;
    v.st = st; v.sck = sck_e; v.strb = strb; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic sck_e,
                         input logic strb, input logic [15:0] fc);
    chk({tag, " state"}, 32'(ctrl_state), 32'(st));
    chk({tag, " busy"},  32'(ctrl_busy),  32'(st != 2'd0));
    chk({tag, " sck"},   32'(sck),        32'(sck_e));
    chk({tag, " strobe"}, 32'(sck_transition), 32'(strb));
    chk({tag, " fcnt"},  32'(ro_frame_cnt), 32'(fc));
  endtask

  task automatic drive_step(input logic en, input logic rts, input logic [7:0] div,
                            input logic ws, input logic trig);
    rf_i2so_en     = en;
    fifo_rts       = rts;
    rf_sck_div     = div;
    i2so_ws        = ws;
    trig_frame_cnt = trig;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rf_i2so_en = 1'b0; rf_sck_div = 8'd0; fifo_rts = 1'b0;
    i2so_ws = 1'b0; trig_frame_cnt = 1'b0;

    // div=4 start, 8-clk sck period, one frame in RUN, drain to final ws fall
    tbl.push_back(mk(1,1,4,0,0, 1,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,1,4,0,0, 1,0,0,0));
    tbl.push_back(mk(1,1,4,0,0, 1,1,1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,1,4,0,0, 1,1,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,1,4,0,0, 1,0,0,0));
    tbl.push_back(mk(1,1,4,0,0, 1,1,1,0));
    tbl.push_back(mk(1,1,4,1,0, 1,1,0,0));
    tbl.push_back(mk(1,1,4,0,0, 1,1,0,1));
    tbl.push_back(mk(0,1,4,0,0, 2,1,0,1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,4,1,0, 2,0,0,1));
    tbl.push_back(mk(0,1,4,1,0, 2,1,1,1));
    tbl.push_back(mk(0,1,4,0,0, 0,0,0,2));
    tbl.push_back(mk(0,1,4,0,0, 0,0,0,2));
    // no fifo data, div=0 as 1, div change ignored in RUN, DRAIN->RUN, clear
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,2));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,2));
    tbl.push_back(mk(1,1,0,0,0, 1,0,0,2));
    tbl.push_back(mk(1,1,0,0,0, 1,1,1,2));
    tbl.push_back(mk(1,1,0,0,0, 1,0,0,2));
    tbl.push_back(mk(1,1,9,0,0, 1,1,1,2));
    tbl.push_back(mk(1,1,9,0,0, 1,0,0,2));
    tbl.push_back(mk(0,1,9,0,0, 2,1,1,2));
    tbl.push_back(mk(0,1,9,0,0, 2,0,0,2));
    tbl.push_back(mk(1,1,9,0,0, 1,1,1,2));
    tbl.push_back(mk(1,1,9,0,0, 1,0,0,2));
    tbl.push_back(mk(0,1,9,1,0, 2,1,1,2));
    tbl.push_back(mk(0,1,9,0,0, 0,0,0,3));
    tbl.push_back(mk(0,1,9,0,0, 0,0,0,3));
    tbl.push_back(mk(0,1,9,0,1, 0,0,0,0));

    #12;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 16'd0);
    #5 rst = 1'b0;
    @(posedge clk); #1;
    chk_all("post_reset", 2'd0, 1'b0, 1'b0, 16'd0);

    foreach (tbl[i]) begin
      drive_step(tbl[i].en, tbl[i].rts, tbl[i].div, tbl[i].ws, tbl[i].trig);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].sck, tbl[i].strb, tbl[i].fc);
    end

    // div=9 latched in IDLE: first strobe exactly 9 clks after entering RUN
    drive_step(1, 1, 9, 0, 0);
    chk_all("div9_enter", 2'd1, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 9; k++) begin
      drive_step(1, 1, 9, 0, 0);
      chk_all($sformatf("div9_c%0d", k), 2'd1, (k == 9), (k == 9), 16'd0);
    end

    // saturation and clear-over-increment
    force dut.fcnt_q = 16'hFFFE;
    #1 release dut.fcnt_q;
    drive_step(1, 1, 9, 1, 0);
    drive_step(1, 1, 9, 0, 0);
    chk("sat_reach", 32'(ro_frame_cnt), 32'hFFFF);
    drive_step(1, 1, 9, 1, 0);
    drive_step(1, 1, 9, 0, 0);
    chk("sat_hold", 32'(ro_frame_cnt), 32'hFFFF);
    drive_step(1, 1, 9, 1, 0);
    drive_step(1, 1, 9, 0, 1);
    chk("clr_wins", 32'(ro_frame_cnt), 32'h0);
    drive_step(1, 1, 9, 1, 0);
    drive_step(1, 1, 9, 0, 0);
    chk("count_after_clr", 32'(ro_frame_cnt), 32'h1);
    chk("run_before_rst", 32'(ctrl_state), 32'd1);

    // asynchronous reset mid-RUN
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 1'b0, 16'd0);
    rf_i2so_en = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk_all("after_rst", 2'd0, 1'b0, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
